// File: rtl/change_dispenser.sv
// change_dispenser
//   Coin-output side of the vending machine. It accepts a refund amount in won
//   and pays it out as one-cycle coin pulses. Coins are chosen largest first
//   from a per-denomination inventory, and any amount that cannot be paid is
//   reported when the payout ends.
//
//   Optional build macro: DISPENSE_GAP_EN. When defined, every coin pulse is
//   followed by one all-low cycle so the actuator can recover.
//
// Parameters
//   INIT_1000/INIT_500/INIT_100/INIT_50 : coins loaded at reset/restock (0..255)
//
// Ports
//   CLK              in   rising-edge clock
//   RST_N            in   synchronous active-low reset
//   IN_REFUND[15:0]  in   refund amount in won
//   IN_REFUND_VALID  in   request strobe
//   IN_RESTOCK       in   reload inventories (only while ready)
//   OUT_READY        out  idle, request can be accepted
//   OUT_1000WON/OUT_500WON/OUT_100WON/OUT_50WON out  one pulse per coin
//   OUT_DONE         out  one-cycle pulse at end of payout
//   OUT_SHORT        out  with OUT_DONE: remainder could not be paid
//   OUT_REMAIN[15:0] out  unpaid won, valid with OUT_DONE, held afterwards
//   OUT_EMPTY[3:0]   out  inventory-zero flags {1000,500,100,50}
//   dbg_state[1:0]   out  current FSM state for observation
//
// Handshake: a request transfers on a rising CLK edge where IN_REFUND_VALID=1
// and OUT_READY=1. With OUT_READY=0 both IN_REFUND_VALID and IN_RESTOCK are
// dropped; nothing is queued.
module change_dispenser #(
  parameter int unsigned INIT_1000 = 10,
  parameter int unsigned INIT_500  = 10,
  parameter int unsigned INIT_100  = 20,
  parameter int unsigned INIT_50   = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IN_REFUND,
  input  logic        IN_REFUND_VALID,
  input  logic        IN_RESTOCK,
  output logic        OUT_READY,
  output logic        OUT_1000WON,
  output logic        OUT_500WON,
  output logic        OUT_100WON,
  output logic        OUT_50WON,
  output logic        OUT_DONE,
  output logic        OUT_SHORT,
  output logic [15:0] OUT_REMAIN,
  output logic [3:0]  OUT_EMPTY,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAY  = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Index 3 is the 1000 won coin, index 0 the 50 won coin, matching OUT_EMPTY.
  localparam logic [3:0][15:0] DENOM = {16'd1000, 16'd500, 16'd100, 16'd50};
  localparam logic [3:0][7:0] INIT_STOCK = {8'(INIT_1000), 8'(INIT_500),
                                            8'(INIT_100), 8'(INIT_50)};

  state_t          state, state_next;
  logic [15:0]     remain, remain_next;
  logic [3:0][7:0] stock, stock_next;
  logic [3:0]      coins, coins_next;
  logic            ready_next;
  logic            done_next;
  logic            short_next;
  logic [15:0]     remain_out_next;
  logic            pick_found;
  logic [1:0]      pick_idx;

  // The loop ascends, so the last payable denomination it sees is the largest one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (remain >= DENOM[i] && stock[i] != 8'd0) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_next      = state;
    remain_next     = remain;
    stock_next      = stock;
    coins_next      = 4'b0000;
    done_next       = 1'b0;
    short_next      = 1'b0;
    remain_out_next = OUT_REMAIN;
    case (state)
      S_IDLE: begin
        // A restock on the accept edge is applied first, so PAY sees the new stock.
        if (IN_RESTOCK) stock_next = INIT_STOCK;
        if (IN_REFUND_VALID) begin
          remain_next = IN_REFUND;
          state_next  = S_PAY;
        end
      end
      S_PAY: begin
        if (pick_found) begin
          coins_next[pick_idx] = 1'b1;
          remain_next          = remain - DENOM[pick_idx];
          stock_next[pick_idx] = stock[pick_idx] - 8'd1;
`ifdef DISPENSE_GAP_EN
          state_next = S_GAP;
`else
          state_next = S_PAY;
`endif
        end else begin
          done_next       = 1'b1;
          short_next      = (remain != 16'd0);
          remain_out_next = remain;
          state_next      = S_FIN;
        end
      end
      S_GAP: state_next = S_PAY;
      S_FIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      remain     <= 16'd0;
      stock      <= INIT_STOCK;
      coins      <= 4'b0000;
      OUT_READY  <= 1'b1;
      OUT_DONE   <= 1'b0;
      OUT_SHORT  <= 1'b0;
      OUT_REMAIN <= 16'd0;
      for (int i = 0; i < 4; i++) OUT_EMPTY[i] <= (INIT_STOCK[i] == 8'd0);
    end else begin
      state      <= state_next;
      remain     <= remain_next;
      stock      <= stock_next;
      coins      <= coins_next;
      OUT_READY  <= ready_next;
      OUT_DONE   <= done_next;
      OUT_SHORT  <= short_next;
      OUT_REMAIN <= remain_out_next;
      // Flags follow the registered counters, so they lag a decrement by one cycle.
      for (int i = 0; i < 4; i++) OUT_EMPTY[i] <= (stock[i] == 8'd0);
    end
  end

  assign OUT_1000WON = coins[3];
  assign OUT_500WON  = coins[2];
  assign OUT_100WON  = coins[1];
  assign OUT_50WON   = coins[0];
  assign dbg_state   = state;

endmodule
